// File: rtl/ninjakun_vram_port.sv
// ninjakun_vram_port: CPU-side video-RAM access port; holds the Z80 in WAIT until a VSLOT grant.
// Optional slot-wait timeout with sticky TMO flag when NINJAKUN_VRAM_TIMEOUT_EN is defined.
module ninjakun_vram_port #(
  parameter int AW = 11,
  parameter int DW = 8
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          CS_FGV,
  input  logic          CS_BGV,
  input  logic          CS_SPA,
  input  logic          CS_PAL,
  input  logic [AW-1:0] CPADR,
  input  logic [DW-1:0] CPDO,
  input  logic          CPRD,
  input  logic          CPWR,
  output logic [DW-1:0] CPDI,
  output logic          CPWAIT_N,
  input  logic          VSLOT,
  output logic [1:0]    RAM_SEL,
  output logic [AW-1:0] RAM_AD,
  output logic [DW-1:0] RAM_DO,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_DI,
  output logic          BUSY
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
  ,
  output logic          TMO
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, ACC, DONE} state_t;

  state_t        state_reg, state_next;
  logic          wait_reg, wait_next;
  logic          we_reg, we_next;
  logic          wr_reg, wr_next;
  logic [1:0]    sel_reg, sel_next;
  logic [AW-1:0] ad_reg, ad_next;
  logic [DW-1:0] do_reg, do_next;
  logic [DW-1:0] cpdi_reg, cpdi_next;
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
  logic [7:0]    cnt_reg, cnt_next;
  logic          tmo_reg, tmo_next;
`endif

  logic       req;
  logic [1:0] bank;

  assign req = (CS_FGV | CS_BGV | CS_SPA | CS_PAL) & (CPRD | CPWR);

  // Lowest-numbered bank wins when the decoder asserts several selects.
  always_comb begin
    bank = 2'd3;
    if (CS_FGV)      bank = 2'd0;
    else if (CS_BGV) bank = 2'd1;
    else if (CS_SPA) bank = 2'd2;
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    we_next    = 1'b0;
    wr_next    = wr_reg;
    sel_next   = sel_reg;
    ad_next    = ad_reg;
    do_next    = do_reg;
    cpdi_next  = cpdi_reg;
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
    cnt_next   = cnt_reg;
    tmo_next   = tmo_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req) begin
          sel_next   = bank;
          ad_next    = CPADR;
          do_next    = CPDO;
          wr_next    = CPWR;
          wait_next  = 1'b0;
          state_next = REQ;
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
          cnt_next   = 8'd0;
`endif
        end
      end
      REQ: begin
        if (VSLOT) begin
          we_next    = wr_reg;
          state_next = ACC;
        end
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
        // Give up on the slot: release the CPU without touching the RAM.
        else if (cnt_reg == 8'(TIMEOUT)) begin
          wait_next  = 1'b1;
          tmo_next   = 1'b1;
          state_next = DONE;
          if (!wr_reg) cpdi_next = '1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end
      ACC: begin
        if (!wr_reg) cpdi_next = RAM_DI;
        wait_next  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        // Wait for the strobes to drop so one CPU cycle gives one access.
        if (!(CPRD | CPWR)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      wait_reg  <= 1'b1;
      we_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      sel_reg   <= 2'd0;
      ad_reg    <= '0;
      do_reg    <= '0;
      cpdi_reg  <= '0;
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
      cnt_reg   <= 8'd0;
      tmo_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      we_reg    <= we_next;
      wr_reg    <= wr_next;
      sel_reg   <= sel_next;
      ad_reg    <= ad_next;
      do_reg    <= do_next;
      cpdi_reg  <= cpdi_next;
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
      cnt_reg   <= cnt_next;
      tmo_reg   <= tmo_next;
`endif
    end
  end

  assign CPDI     = cpdi_reg;
  assign CPWAIT_N = wait_reg;
  assign RAM_SEL  = sel_reg;
  assign RAM_AD   = ad_reg;
  assign RAM_DO   = do_reg;
  assign RAM_WE   = we_reg;
  assign BUSY     = (state_reg != IDLE);
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
  assign TMO      = tmo_reg;
`endif

endmodule

// File: tb/tb_ninjakun_vram_port.sv
// Testbench for ninjakun_vram_port: bench-side shared RAM plus a transaction-level reference
// (expected bank, wait length, RAM contents, CPDI) built from the access rules.
`timescale 1ns/1ps
module tb_ninjakun_vram_port;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_fgv = 1'b0, cs_bgv = 1'b0, cs_spa = 1'b0, cs_pal = 1'b0;
  logic [AW-1:0] cpadr = '0;
  logic [DW-1:0] cpdo = '0;
  logic          cprd = 1'b0, cpwr = 1'b0, vslot = 1'b0;
  logic [DW-1:0] cpdi;
  logic          cpwait_n;
  logic [1:0]    ram_sel;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_do;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic          busy;
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
  logic          tmo;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ninjakun_vram_port #(.AW(AW), .DW(DW)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .CS_FGV(cs_fgv), .CS_BGV(cs_bgv), .CS_SPA(cs_spa), .CS_PAL(cs_pal),
    .CPADR(cpadr), .CPDO(cpdo), .CPRD(cprd), .CPWR(cpwr),
    .CPDI(cpdi), .CPWAIT_N(cpwait_n), .VSLOT(vslot),
    .RAM_SEL(ram_sel), .RAM_AD(ram_ad), .RAM_DO(ram_do), .RAM_WE(ram_we),
    .RAM_DI(ram_di), .BUSY(busy)
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
    , .TMO(tmo)
`endif
  );

  function automatic logic [7:0] init_val(input logic [1:0] s, input logic [10:0] a);
    return a[7:0] ^ {a[10:8], 3'b000, s} ^ 8'h3C;
  endfunction

  // Shared RAM seen by the DUT: registered read, write on RAM_WE.
  logic [7:0] ram [0:3][0:2047];
  bit         ram_vld [0:3][0:2047];
  logic       pl_en = 1'b0;
  logic [1:0] pl_sel = '0;
  logic [10:0] pl_ad = '0;
  logic [7:0] pl_dat = '0;
  int         we_cnt = 0;
  logic [1:0] we_sel;
  logic [10:0] we_ad;
  logic [7:0] we_do;

  always @(posedge clk) begin
    ram_di <= ram_vld[ram_sel][ram_ad] ? ram[ram_sel][ram_ad] : init_val(ram_sel, ram_ad);
    if (ram_we) begin
      ram[ram_sel][ram_ad]     <= ram_do;
      ram_vld[ram_sel][ram_ad] <= 1'b1;
      we_cnt <= we_cnt + 1;
      we_sel <= ram_sel;
      we_ad  <= ram_ad;
      we_do  <= ram_do;
    end else if (pl_en) begin
      ram[pl_sel][pl_ad]     <= pl_dat;
      ram_vld[pl_sel][pl_ad] <= 1'b1;
    end
  end

  // Reference state
  logic [7:0] ref_mem [0:3][0:2047];
  logic [7:0] exp_cpdi = 8'h00;
  bit         exp_tmo = 1'b0;

  function automatic logic [1:0] exp_bank(input logic [3:0] cs);
    if (cs[0]) return 2'd0;
    if (cs[1]) return 2'd1;
    if (cs[2]) return 2'd2;
    return 2'd3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cs(input logic [3:0] cs);
    {cs_pal, cs_spa, cs_bgv, cs_fgv} = cs;
  endtask

  task automatic preload(input logic [1:0] s, input logic [10:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_sel = s; pl_ad = a; pl_dat = d;
    step();
    pl_en = 1'b0;
    ref_mem[s][a] = d;
  endtask

  // One CPU access; k = edge (after the request edge) carrying VSLOT, 0 = never.
  task automatic do_access(input string tag, input logic [3:0] cs, input logic rd, input logic wr,
                           input logic [10:0] a, input logic [7:0] d, input int k,
                           input int hold, input logic early_vslot);
    int base_we, len, exp_len, hold_bad;
    logic [1:0] b;
    bit timed_out;
    b = exp_bank(cs);
    timed_out = (k == 0);
    exp_len = timed_out ? TIMEOUT + 2 : k + 2;
    base_we = we_cnt;
    set_cs(cs); cprd = rd; cpwr = wr; cpadr = a; cpdo = d; vslot = early_vslot;
    step();
    total++;
    if (cpwait_n !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s req_edge: cpwait_n=%b busy=%b want 0 1", tag, cpwait_n, busy);
    else if (0) ;
    if (cpwait_n !== 1'b0 || busy !== 1'b1) bad++;
    total++;
    if (ram_sel !== b || ram_ad !== a) begin
      $display("FAIL %s ram_addr: sel=%0d ad=%h want sel=%0d ad=%h", tag, ram_sel, ram_ad, b, a);
      bad++;
    end
    // Bus may change once captured; the latched access must still complete.
    set_cs(4'($urandom_range(0, 15))); cpadr = 11'($urandom); cpdo = 8'($urandom);
    len = 0;
    for (int e = 1; e <= 600 && len == 0; e++) begin
      vslot = (e == k);
      step();
      if (cpwait_n === 1'b1) len = e + 1;
    end
    vslot = 1'b0;
    total++;
    if (len != exp_len) begin
      $display("FAIL %s wait_len: got %0d want %0d", tag, len, exp_len);
      bad++;
    end
    if (wr && !timed_out) ref_mem[b][a] = d;
    if (!wr) exp_cpdi = timed_out ? 8'hFF : ref_mem[b][a];
    if (timed_out) exp_tmo = 1'b1;
    total++;
    if (we_cnt - base_we != ((wr && !timed_out) ? 1 : 0)) begin
      $display("FAIL %s we_pulses: got %0d want %0d", tag, we_cnt - base_we, (wr && !timed_out) ? 1 : 0);
      bad++;
    end
    if (wr && !timed_out) begin
      total++;
      if (we_sel !== b || we_ad !== a || we_do !== d) begin
        $display("FAIL %s write: sel=%0d ad=%h do=%h want sel=%0d ad=%h do=%h",
                 tag, we_sel, we_ad, we_do, b, a, d);
        bad++;
      end
    end
    total++;
    if (cpdi !== exp_cpdi) begin
      $display("FAIL %s cpdi: got %h want %h", tag, cpdi, exp_cpdi);
      bad++;
    end
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      vslot = (i % 4 == 0);
      step();
      if (cpwait_n !== 1'b1 || busy !== 1'b1) hold_bad++;
    end
    vslot = 1'b0;
    total++;
    if (hold_bad != 0) begin
      $display("FAIL %s hold: bad_cycles=%0d want 0", tag, hold_bad);
      bad++;
    end
    cprd = 1'b0; cpwr = 1'b0; set_cs(4'b0000);
    step();
    total++;
    if (busy !== 1'b0 || we_cnt - base_we != ((wr && !timed_out) ? 1 : 0)) begin
      $display("FAIL %s release: busy=%b we_pulses=%0d want busy=0", tag, busy, we_cnt - base_we);
      bad++;
    end
    $display("txn %s cs=%b rd=%b wr=%b a=%h d=%h k=%0d len=%0d cpdi=%h", tag, cs, rd, wr, a, d, k, len, cpdi);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if (cpwait_n !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0) begin
      $display("FAIL reset_ctl: cpwait_n=%b busy=%b we=%b want 1 0 0", cpwait_n, busy, ram_we);
      bad++;
    end
    total++;
    if (cpdi !== 8'h00 || ram_sel !== 2'd0 || ram_ad !== 11'd0 || ram_do !== 8'h00) begin
      $display("FAIL reset_data: cpdi=%h sel=%0d ad=%h do=%h want zeros", cpdi, ram_sel, ram_ad, ram_do);
      bad++;
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    preload(2'd0, 11'h123, 8'h5A);
    do_access("read", 4'b0001, 1'b1, 1'b0, 11'h123, 8'h00, 5, 0, 1'b0);
  endtask

  task automatic test_write();
    do_access("write", 4'b1000, 1'b0, 1'b1, 11'h7FF, 8'hC3, 1, 0, 1'b0);
    total++;
    if (ram_do !== 8'hC3 || ram_we !== 1'b0) begin
      $display("FAIL write_hold: do=%h we=%b want c3 0", ram_do, ram_we);
      bad++;
    end
  endtask

  task automatic test_hold();
    do_access("hold", 4'b0010, 1'b1, 1'b0, 11'h040, 8'h00, 3, 20, 1'b1);
  endtask

  task automatic test_priority();
    do_access("prio", 4'b0110, 1'b1, 1'b1, 11'h2A5, 8'h96, 2, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [3:0] cs;
      logic rd, wr;
      logic [10:0] a;
      cs = 4'($urandom_range(1, 15));
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      a = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 7)) : 11'($urandom);
      do_access("rand", cs, rd, wr, a, 8'($urandom), $urandom_range(1, 9),
                $urandom_range(0, 5), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    do_access("b2b_w", 4'b0100, 1'b0, 1'b1, 11'h3, 8'h11, 1, 0, 1'b1);
    do_access("b2b_r", 4'b0100, 1'b1, 1'b0, 11'h3, 8'h00, 1, 0, 1'b1);
    do_access("b2b_w2", 4'b0100, 1'b0, 1'b1, 11'h3, 8'hEE, 2, 0, 1'b0);
    do_access("b2b_r2", 4'b1100, 1'b1, 1'b0, 11'h3, 8'h00, 1, 0, 1'b0);
  endtask

`ifdef NINJAKUN_VRAM_TIMEOUT_EN
  task automatic test_timeout();
    total++;
    if (tmo !== 1'b0) begin
      $display("FAIL tmo_before: got %b want 0", tmo);
      bad++;
    end
    do_access("tmo_rd", 4'b0001, 1'b1, 1'b0, 11'h155, 8'h00, 0, 0, 1'b0);
    do_access("tmo_wr", 4'b0010, 1'b0, 1'b1, 11'h155, 8'h77, 0, 0, 1'b0);
    do_access("after_tmo", 4'b0001, 1'b1, 1'b0, 11'h123, 8'h00, 2, 0, 1'b0);
    total++;
    if (tmo !== exp_tmo) begin
      $display("FAIL tmo_sticky: got %b want %b", tmo, exp_tmo);
      bad++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    int base_we, late_bad;
    base_we = we_cnt;
    set_cs(4'b0001); cpwr = 1'b1; cpadr = 11'h0AA; cpdo = 8'h5F;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    total++;
    if (cpwait_n !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0 || cpdi !== 8'h00) begin
      $display("FAIL reset_mid: cpwait_n=%b busy=%b we=%b cpdi=%h want 1 0 0 00", cpwait_n, busy, ram_we, cpdi);
      bad++;
    end
    exp_cpdi = 8'h00;
    exp_tmo = 1'b0;
    cpwr = 1'b0;
    step();
    #2 rst_n = 1'b1;
    late_bad = 0;
    for (int i = 0; i < 10; i++) begin
      vslot = (i % 2 == 0);
      step();
      if (busy !== 1'b0 || cpwait_n !== 1'b1) late_bad++;
    end
    vslot = 1'b0;
    set_cs(4'b0000);
    total++;
    if (we_cnt != base_we || late_bad != 0) begin
      $display("FAIL reset_no_write: we_pulses=%0d bad_cycles=%0d want 0 0", we_cnt - base_we, late_bad);
      bad++;
    end
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
    total++;
    if (tmo !== 1'b0) begin
      $display("FAIL tmo_reset: got %b want 0", tmo);
      bad++;
    end
`endif
    do_access("post_rst", 4'b0001, 1'b1, 1'b0, 11'h0AA, 8'h00, 1, 0, 1'b0);
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 2048; a++)
        ref_mem[s][a] = init_val(2'(s), 11'(a));
    test_reset();
    test_read();
    test_write();
    test_hold();
    test_priority();
    test_back_to_back();
    test_random();
`ifdef NINJAKUN_VRAM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
